// File: rtl/neopx_pkg.sv
// Shared WS2812 constants and types for the NeoPixel TX/RX pair.
// All bit timings are expressed in 72 MHz clock cycles.
package neopx_pkg;

  localparam int T0H_CYC   = 29;    // 0.40 us
  localparam int T1H_CYC   = 58;    // 0.80 us
  localparam int T0L_CYC   = 61;    // 0.85 us
  localparam int T1L_CYC   = 32;    // 0.45 us
  localparam int RESET_CYC = 3600;  // 50 us latch gap
  localparam int PIX_BITS  = 24;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/neopx_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line, with
// single-cycle rise/fall pulses taken from the synchronized value.
module neopx_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   dly_q, dly_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], i_async};
    dly_d   = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      dly_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      dly_q   <= dly_d;
    end
  end

  assign o_sync = chain_q[SYNC_STAGES-1];
  assign o_rise = o_sync & ~dly_q;
  assign o_fall = ~o_sync & dly_q;

endmodule

// File: rtl/neopx_rx.sv
// WS2812 bitstream receiver: pulse-width decode into 24-bit pixels on AXI-Stream.
// Optional NEOPX_RX_ERRCNT_EN adds a saturating error counter with sync clear.
module neopx_rx
  import neopx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_HIGH_count = 8,
  parameter int THRESH_count   = (T0H_CYC + T1H_CYC) / 2,
  parameter int MAX_HIGH_count = 108,
  parameter int RESET_count    = RESET_CYC
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        i_serial,
  output logic [31:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        m_axis_user,
  output logic        o_latch,
  output logic        o_err,
`ifdef NEOPX_RX_ERRCNT_EN
  output logic [15:0] o_err_count,
  input  logic        i_err_clr,
`endif
  output logic        o_overflow
);

  localparam logic [15:0] MIN_C   = 16'(MIN_HIGH_count);
  localparam logic [15:0] THR_C   = 16'(THRESH_count);
  localparam logic [15:0] MAX_C   = 16'(MAX_HIGH_count);
  localparam logic [15:0] RESET_C = 16'(RESET_count);
  localparam logic [4:0]  LAST_B  = 5'(PIX_BITS - 1);

  logic ser, rise, fall;

  neopx_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (axis_aclk),
    .rst_n  (axis_aresetn),
    .i_async(i_serial),
    .o_sync (ser),
    .o_rise (rise),
    .o_fall (fall)
  );

  rx_state_e             state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [PIX_BITS-1:0]   shift_q, shift_d;
  logic [PIX_BITS-1:0]   data_q, data_d;
  logic                  first_pix_q, first_pix_d;
  logic                  valid_q, valid_d;
  logic                  user_q, user_d;
  logic                  latch_q, latch_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic                  pix_done, accept, load;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    first_pix_d = first_pix_q;
    valid_d     = valid_q;
    user_d      = user_q;
    ovf_d       = ovf_q;
    latch_d     = 1'b0;
    err_d       = 1'b0;
    pix_done    = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (ser) begin
          cnt_d = '0;
        end else begin
          cnt_d = sat_inc16(cnt_q);
          // Initial alignment: no latch pulse, just arm the frame start.
          if (cnt_d >= RESET_C) begin
            state_d     = ST_IDLE;
            first_pix_d = 1'b1;
            bit_cnt_d   = '0;
          end
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = 16'd1;
        end else begin
          cnt_d = sat_inc16(cnt_q);
          if (cnt_d == RESET_C) begin
            latch_d     = 1'b1;
            first_pix_d = 1'b1;
            if (bit_cnt_q != '0) begin
              err_d     = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
      end
      ST_HIGH: begin
        cnt_d = sat_inc16(cnt_q);
        if (cnt_q > MAX_C) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = ST_SYNC;
        end else if (fall) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (cnt_q < MIN_C) begin
            err_d = 1'b1;
          end else begin
            shift_d = {shift_q[PIX_BITS-2:0], (cnt_q >= THR_C)};
            if (bit_cnt_q == LAST_B) begin
              bit_cnt_d = '0;
              pix_done  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase

    // Single-entry output register; a concurrent accept frees it for reload.
    accept = valid_q & m_axis_ready;
    load   = pix_done & (~valid_q | accept);
    if (accept) valid_d = 1'b0;
    if (load) begin
      valid_d     = 1'b1;
      data_d      = shift_d;
      user_d      = first_pix_q;
      first_pix_d = 1'b0;
    end
    if (pix_done & ~load) begin
      err_d = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      first_pix_q <= 1'b0;
      valid_q     <= 1'b0;
      user_q      <= 1'b0;
      latch_q     <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      first_pix_q <= first_pix_d;
      valid_q     <= valid_d;
      user_q      <= user_d;
      latch_q     <= latch_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign m_axis_data  = {8'h00, data_q};
  assign m_axis_valid = valid_q;
  assign m_axis_user  = user_q;
  assign o_latch      = latch_q;
  assign o_err        = err_q;
  assign o_overflow   = ovf_q;

`ifdef NEOPX_RX_ERRCNT_EN
  logic [15:0] errc_q, errc_d;

  // Clear wins over history but not over an error in the same cycle.
  always_comb begin
    errc_d = errc_q;
    if (i_err_clr)  errc_d = {15'd0, err_q};
    else if (err_q) errc_d = sat_inc16(errc_q);
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) errc_q <= '0;
    else               errc_q <= errc_d;
  end

  assign o_err_count = errc_q;
`endif

endmodule

// File: tb/tb_neopx_rx.sv
// Directed bench for neopx_rx: drives WS2812 waveforms and checks beats,
// latch/error pulses and overflow against hand-computed expectations.
module tb_neopx_rx;
  import neopx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ser = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] m_data;
  logic        m_valid, m_user, latch, err, ovf;
`ifdef NEOPX_RX_ERRCNT_EN
  logic [15:0] err_count;
  logic        err_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  neopx_rx dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst_n),
    .i_serial    (ser),
    .m_axis_data (m_data),
    .m_axis_valid(m_valid),
    .m_axis_ready(rdy),
    .m_axis_user (m_user),
    .o_latch     (latch),
    .o_err       (err),
`ifdef NEOPX_RX_ERRCNT_EN
    .o_err_count (err_count),
    .i_err_clr   (err_clr),
`endif
    .o_overflow  (ovf)
  );

  int n_chk = 0, n_pass = 0;
  int lat_n = 0, err_n = 0, both_n = 0;
  int b0, l0, e0, x0;
  logic [31:0] bq_data[$];
  logic        bq_user[$];

  // Inputs change at posedge+1, so the negedge sees a settled handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && rdy) begin
        bq_data.push_back(m_data);
        bq_user.push_back(m_user);
      end
      if (latch) lat_n++;
      if (err) err_n++;
      if (latch && err) both_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b0 = bq_data.size();
    l0 = lat_n;
    e0 = err_n;
    x0 = both_n;
  endtask

  task automatic send_bit(input logic b);
    ser = 1'b1;
    cyc(b ? T1H_CYC : T0H_CYC);
    ser = 1'b0;
    cyc(b ? T1L_CYC : T0L_CYC);
  endtask

  task automatic send_bits(input logic [23:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) send_bit(d[23-i]);
  endtask

  task automatic send_pix(input logic [23:0] d);
    send_bits(d, 0, 23);
  endtask

  task automatic glitch_pix();
    send_bits(24'h0F0F0F, 0, 10);
    ser = 1'b1;
    cyc(5);
    ser = 1'b0;
    cyc(30);
    send_bits(24'h0F0F0F, 11, 23);
  endtask

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_user", m_user, 0);
    chk("rst_latch", latch, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    cyc(3);
    rst_n = 1'b1;

    // 1: alignment then single pixel
    snap();
    cyc(3700);
    send_pix(24'hA5C3F0);
    chk("t1_beats", bq_data.size() - b0, 1);
    chk("t1_data", bq_data[b0], 32'h00A5C3F0);
    chk("t1_user", bq_user[b0], 1);
    cyc(4000);
    chk("t1_latch", lat_n - l0, 1);
    chk("t1_err", err_n - e0, 0);

    // 2: three pixels back to back
    snap();
    send_pix(24'h112233); cyc(15);
    send_pix(24'h445566); cyc(15);
    send_pix(24'h778899); cyc(15);
    chk("t2_nolatch", lat_n - l0, 0);
    chk("t2_beats", bq_data.size() - b0, 3);
    chk("t2_d0", bq_data[b0], 32'h00112233);
    chk("t2_d1", bq_data[b0+1], 32'h00445566);
    chk("t2_d2", bq_data[b0+2], 32'h00778899);
    chk("t2_u0", bq_user[b0], 1);
    chk("t2_u1", bq_user[b0+1], 0);
    chk("t2_u2", bq_user[b0+2], 0);
    cyc(4000);
    chk("t2_latch", lat_n - l0, 1);
    chk("t2_err", err_n - e0, 0);

    // 3: overflow with ready low
    snap();
    rdy = 1'b0;
    send_pix(24'hAABBCC); cyc(15);
    chk("t3_valid1", m_valid, 1);
    chk("t3_data1", m_data, 32'h00AABBCC);
    send_pix(24'h123456); cyc(15);
    chk("t3_hold", m_data, 32'h00AABBCC);
    chk("t3_valid2", m_valid, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_err", err_n - e0, 1);
    rdy = 1'b1;
    cyc(5);
    chk("t3_beats", bq_data.size() - b0, 1);
    chk("t3_bdata", bq_data[b0], 32'h00AABBCC);
    chk("t3_drain", m_valid, 0);
    cyc(4000);

    // 4a: short glitch inside a pixel
    snap();
    glitch_pix();
    chk("t4_gerr", err_n - e0, 1);
    chk("t4_gbeats", bq_data.size() - b0, 1);
    chk("t4_gdata", bq_data[b0], 32'h000F0F0F);
    cyc(4000);

    // 4b: over-long high forces resync
    snap();
    ser = 1'b1; cyc(150); ser = 1'b0; cyc(100);
    send_pix(24'h555555);
    cyc(4000);
    chk("t4_lerr", err_n - e0, 1);
    chk("t4_lbeats", bq_data.size() - b0, 0);
    chk("t4_llatch", lat_n - l0, 0);
    snap();
    send_pix(24'h13579B);
    cyc(4000);
    chk("t4_rbeats", bq_data.size() - b0, 1);
    chk("t4_rdata", bq_data[b0], 32'h0013579B);
    chk("t4_ruser", bq_user[b0], 1);
    chk("t4_rlatch", lat_n - l0, 1);

    // 5: partial pixel at latch gap
    snap();
    send_bits(24'hABC000, 0, 11);
    cyc(4000);
    chk("t5_latch", lat_n - l0, 1);
    chk("t5_err", err_n - e0, 1);
    chk("t5_same", both_n - x0, 1);
    chk("t5_beats", bq_data.size() - b0, 0);
    snap();
    send_pix(24'h00FF00);
    cyc(4000);
    chk("t5_nbeats", bq_data.size() - b0, 1);
    chk("t5_ndata", bq_data[b0], 32'h0000FF00);
    chk("t5_nuser", bq_user[b0], 1);

    // 6: async reset mid-pixel
    rdy = 1'b0;
    send_pix(24'hC0FFEE);
    cyc(10);
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_user", m_user, 1);
    chk("t6_pre_ovf", ovf, 1);
    send_bits(24'h5A5A5A, 0, 9);
    ser = 1'b1;
    cyc(10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_data", m_data, 0);
    chk("t6_user", m_user, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_latch", latch, 0);
    chk("t6_err", err, 0);
    cyc(3);
    ser = 1'b0;
    rdy = 1'b1;
    rst_n = 1'b1;
    snap();
    send_pix(24'h777777);
    cyc(4000);
    chk("t6_ign_beats", bq_data.size() - b0, 0);
    chk("t6_ign_latch", lat_n - l0, 0);
    snap();
    send_pix(24'h246801);
    cyc(100);
    chk("t6_rbeats", bq_data.size() - b0, 1);
    chk("t6_rdata", bq_data[b0], 32'h00246801);
    chk("t6_ruser", bq_user[b0], 1);

`ifdef NEOPX_RX_ERRCNT_EN
    chk("ec_start", err_count, 0);
    cyc(4000);
    glitch_pix();
    cyc(4000);
    ser = 1'b1; cyc(150); ser = 1'b0; cyc(20);
    chk("ec_two", err_count, 2);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0; cyc(2);
    chk("ec_clr", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neopx_rx.md
Name: neopx_rx

Overview:
- WS2812 one-wire bitstream receiver: the far end of the NeoPixel transmit path.
- Oversamples the serial line on axis_aclk (72 MHz), classifies each high pulse as a 0 or 1 bit, and assembles 24-bit pixels MSB-first.
- Delivers each pixel on an AXI-Stream master. Frames are delimited by the latch (reset) low gap.
- Used for loopback self-test of the strip driver and for monitoring a daisy-chained strip segment.

Parameters:
- SYNC_STAGES, 2, flops in the input synchronizer (minimum 2).
- MIN_HIGH_count, 8, high pulses shorter than this many cycles are glitches.
- THRESH_count, 43, measured high length >= THRESH_count decodes as 1, otherwise 0.
- MAX_HIGH_count, 108, high pulse longer than this (~1.5 us) is a protocol error.
- RESET_count, 3600, continuous low cycles that constitute a latch gap (50 us at 72 MHz).

Ports:
- axis_aclk  input  1  system clock, 72 MHz.
- axis_aresetn  input  1  asynchronous active-low reset.
- i_serial  input  1  WS2812 data line, asynchronous to axis_aclk.
- m_axis_data  output  32  {8'h00, pixel[23:0]}; the first received bit is at bit 23.
- m_axis_valid  output  1  pixel available.
- m_axis_ready  input  1  downstream accepts.
- m_axis_user  output  1  set on the first pixel after a latch gap.
- o_latch  output  1  one-cycle pulse when a latch gap is detected.
- o_err  output  1  one-cycle pulse on glitch, over-long high, partial pixel, or overflow.
- o_overflow  output  1  sticky; set when a pixel is dropped; cleared only by reset.

Behaviour:
- Reset is async on assertion; the deassertion is synchronous to axis_aclk. While reset is asserted:
  - state = SYNC; counters = 0; bit_cnt = 0; shift = 0.
  - m_axis_valid = 0, m_axis_data = 0, m_axis_user = 0.
  - o_latch = 0, o_err = 0, o_overflow = 0.
  - Synchronizer flops = 0.
- i_serial passes through the SYNC_STAGES flop chain. Edge detection uses the synchronized value and its one-cycle delay.
- cnt is a 16-bit cycle counter that saturates at 16'hFFFF.
- FSM states and transitions:
  - SYNC: discard all data until the line has been low for RESET_count consecutive cycles. Then go to IDLE with first_pix = 1. o_latch is not pulsed on this initial alignment.
  - IDLE: line low, cnt increments.
    - If cnt reaches RESET_count: pulse o_latch; set first_pix = 1.
    - If bit_cnt != 0 at that point: discard the partial pixel, pulse o_err, clear bit_cnt.
    - On rising edge: cnt = 1, go to HIGH.
  - HIGH: cnt increments while the line stays high.
    - If cnt > MAX_HIGH_count: pulse o_err, clear bit_cnt, go to SYNC.
    - On falling edge with cnt < MIN_HIGH_count: glitch. Pulse o_err, leave bit_cnt unchanged, go to IDLE with cnt = 0.
    - On falling edge otherwise: shift in (cnt >= THRESH_count) at the LSB and increment bit_cnt. cnt = 0, go to IDLE.
- Pixel completion: when bit_cnt reaches 24 (5-bit counter, 0..23 then wrap to 0), the assembled pixel is offered to the output register in the same cycle as the falling edge. Latency from the 24th falling edge at the synchronizer output to m_axis_valid is 1 cycle.
- Output register: single entry.
  - Loads when empty, or when m_axis_valid & m_axis_ready in the same cycle (simultaneous accept and complete loads the new pixel with no bubble).
  - If full and not being accepted: the new pixel is dropped, o_err pulses, o_overflow sets.
  - On load, m_axis_user = first_pix and first_pix clears.
  - m_axis_data, m_axis_user and m_axis_valid are held stable until the handshake.
- A latch detected while the output register is full does not disturb it.
- Reset mid-frame: all state is lost; after release the block re-enters SYNC.

Optional Feature:
- NEOPX_RX_ERRCNT_EN defined:
  - Adds output o_err_count [15:0]: a saturating count of o_err pulses.
  - Adds input i_err_clr [0:0]: synchronous clear. If a clear and an error occur in the same cycle, the count becomes 1.
- Undefined: neither port exists and no counter logic is synthesized.

Decomposition:
- Shared package neopx_pkg:
  - Timing localparams common to TX and RX: 72 MHz counts for T0H/T1H/T0L/T1L/RESET.
  - The FSM state encoding typedef (SYNC, IDLE, HIGH).
  - Pixel width constant, PIX_BITS = 24.
- One sub-module: neopx_rx_sync, the parameterized SYNC_STAGES synchronizer plus rise/fall edge-pulse outputs.

Test Plan:
1. Hold the line low 3600 cycles, then send bits from a real transmitter with data 32'h00A5C3F0, followed by a 4000-cycle low -> after the 24th bit, m_axis_data = 32'h00A5C3F0, m_axis_user = 1, one o_latch pulse, o_err never pulses.
2. Send three pixels back to back (15-cycle inter-pixel gap) with m_axis_ready held high -> three beats 0x112233, 0x445566, 0x778899; user = 1 only on the first beat; no o_latch until the trailing gap.
3. Hold m_axis_ready low and send two pixels -> the first is held stable, the second is dropped, o_err pulses once, o_overflow = 1; after ready goes high only the first pixel transfers.
4. Inject a 5-cycle high glitch between bits 10 and 11 of 0x0F0F0F -> o_err pulses once and the pixel still decodes as 0x0F0F0F. Separately inject a 150-cycle high -> o_err, FSM returns to SYNC, and the next pixel is ignored until a 3600-cycle low.
5. Send 12 bits followed by a 4000-cycle low -> o_latch and o_err pulse in the same cycle, no beat is emitted, and the next pixel has user = 1.
6. Assert axis_aresetn low for 3 cycles mid-pixel -> all outputs read 0 immediately (asynchronously). With NEOPX_RX_ERRCNT_EN defined, run scenario 4 -> o_err_count = 2; pulse i_err_clr -> 0.
